// File: rtl/phy_pkg.sv
// Shared definitions for the PHY transmit word buffer: word width, read-side
// pacing states and a width helper.
package phy_pkg;

    localparam int PHY_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } rd_state_e;

    // Constant-elaboration log2 ceiling, used for pointer and counter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/phy_tx_fifo_core.sv
// Synchronous word FIFO with registered fill level and flags, plus a sticky
// overflow flag for pushes rejected while full.
module phy_tx_fifo_core
    import phy_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    localparam int PTR_W    = clog2(DEPTH),
    localparam int FILL_W   = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [PHY_WORD_W-1:0] data_in,
    input  logic                  pop,
    output logic [PHY_WORD_W-1:0] rd_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [FILL_W-1:0]     fill_level,
    output logic                  overflow
);

    logic [PHY_WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_overflow;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [FILL_W-1:0]     w_fill_next;

    // Rejection looks only at the registered full flag, so a same-edge pop
    // never rescues a push into a full buffer.
    assign w_push_ok = push && !r_full;
    assign w_pop_ok  = pop && !r_empty;

    always_comb begin
        w_fill_next = r_fill;
        if (w_push_ok && !w_pop_ok) begin
            w_fill_next = r_fill + FILL_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_fill_next = r_fill - FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill        <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap naturally.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (push && r_full) begin
                r_overflow <= 1'b1;
            end
            r_fill        <= w_fill_next;
            r_full        <= (w_fill_next == FILL_W'(DEPTH));
            r_empty       <= (w_fill_next == '0);
            r_almost_full <= (w_fill_next >= FILL_W'(AF_THRESH));
        end
    end

    assign rd_data     = r_mem[r_rd_ptr];
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign empty       = r_empty;
    assign fill_level  = r_fill;
    assign overflow    = r_overflow;

endmodule

// File: rtl/phy_tx_word_buffer.sv
// PHY transmit feeder: buffers producer words and releases them to the PHY
// input bus as one-cycle valid strobes spaced WORD_PERIOD clocks apart.
module phy_tx_word_buffer
    import phy_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WORD_PERIOD = 1,
    parameter int AF_THRESH   = 6,
    localparam int FILL_W     = clog2(DEPTH) + 1,
    localparam int CNT_W      = clog2(WORD_PERIOD) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [PHY_WORD_W-1:0] data_in,
    input  logic                  pause,
    output logic [PHY_WORD_W-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [FILL_W-1:0]     fill_level,
    output logic                  overflow
);

    rd_state_e             r_state;
    rd_state_e             w_state_next;
    logic [CNT_W-1:0]      r_slot_cnt;
    logic [CNT_W-1:0]      w_slot_cnt_next;
    logic                  r_valid;
    logic [PHY_WORD_W-1:0] r_data_out;
    logic                  w_pop;
    logic                  w_can_pop;
    logic                  w_empty;
    logic [PHY_WORD_W-1:0] w_rd_data;

    phy_tx_fifo_core #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .data_in     (data_in),
        .pop         (w_pop),
        .rd_data     (w_rd_data),
        .full        (full),
        .almost_full (almost_full),
        .empty       (w_empty),
        .fill_level  (fill_level),
        .overflow    (overflow)
    );

    assign w_can_pop = !w_empty && !pause;

    // SEND plus the GAP countdown plus the IDLE pop edge add up to exactly
    // WORD_PERIOD edges between strobes; period 2 skips GAP entirely.
    always_comb begin
        w_state_next    = r_state;
        w_slot_cnt_next = r_slot_cnt;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (WORD_PERIOD == 1) begin
                    if (w_can_pop) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_slot_cnt_next = CNT_W'(WORD_PERIOD - 2);
                    w_state_next    = (WORD_PERIOD == 2) ? IDLE : GAP;
                end
            end
            GAP: begin
                w_slot_cnt_next = r_slot_cnt - CNT_W'(1);
                if (r_slot_cnt <= CNT_W'(1)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_slot_cnt <= '0;
            r_valid    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_next;
            r_slot_cnt <= w_slot_cnt_next;
            r_valid    <= w_pop;
            if (w_pop) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign empty    = w_empty;

endmodule

// File: tb/tb_phy_tx_word_buffer.sv
// Scoreboard bench: three instances (WORD_PERIOD 1, 3, 4) share stimulus;
// the instance under test is selected per scenario and its output checked.
module tb_phy_tx_word_buffer;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pause;
    logic [31:0] data_in;

    logic [31:0] dout [3];
    logic        vld  [3];
    logic        ful  [3];
    logic        af   [3];
    logic        emp  [3];
    logic        ovf  [3];
    logic [3:0]  fl   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int act      = 0;

    logic [31:0] sb[$];
    int          vtimes[$];

    phy_tx_word_buffer #(.DEPTH(8), .WORD_PERIOD(1), .AF_THRESH(6)) u_p1 (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pause(pause),
        .data_out(dout[0]), .valid(vld[0]), .full(ful[0]), .almost_full(af[0]),
        .empty(emp[0]), .fill_level(fl[0]), .overflow(ovf[0])
    );

    phy_tx_word_buffer #(.DEPTH(8), .WORD_PERIOD(3), .AF_THRESH(6)) u_p3 (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pause(pause),
        .data_out(dout[1]), .valid(vld[1]), .full(ful[1]), .almost_full(af[1]),
        .empty(emp[1]), .fill_level(fl[1]), .overflow(ovf[1])
    );

    phy_tx_word_buffer #(.DEPTH(8), .WORD_PERIOD(4), .AF_THRESH(6)) u_p4 (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pause(pause),
        .data_out(dout[2]), .valid(vld[2]), .full(ful[2]), .almost_full(af[2]),
        .empty(emp[2]), .fill_level(fl[2]), .overflow(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe from the selected instance is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && vld[act]) begin
            vtimes.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid inst=%0d cyc=%0d data=%h", act, cyc, dout[act]);
            end else begin
                logic [31:0] exp_w;
                exp_w = sb.pop_front();
                if (dout[act] !== exp_w) begin
                    failures++;
                    $display("FAIL data_out inst=%0d cyc=%0d got=%h exp=%h", act, cyc, dout[act], exp_w);
                end else begin
                    $display("word inst=%0d cyc=%0d data=%h", act, cyc, dout[act]);
                end
            end
        end
    end

    task automatic do_reset(input int sel);
        @(posedge clk);
        #2;
        reset = 1'b1;
        push  = 1'b0;
        sb.delete();
        vtimes.delete();
        act = sel;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input bit accept);
        push    = 1'b1;
        data_in = d;
        if (accept) sb.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valids(input int n, input int budget);
        int b;
        b = budget;
        while (vtimes.size() < n && b > 0) begin
            @(posedge clk);
            b--;
        end
        #1;
        checks++;
        if (vtimes.size() < n) begin
            failures++;
            $display("FAIL valid_timeout got=%0d exp=%0d", vtimes.size(), n);
        end
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({vld[i], emp[i], ful[i], af[i], ovf[i], fl[i]} !== 9'b0_1_0_0_0_0000) begin
                failures++;
                $display("FAIL reset_flags inst=%0d got=%b exp=%b", i,
                         {vld[i], emp[i], ful[i], af[i], ovf[i], fl[i]}, 9'b0_1_0_0_0_0000);
            end
            checks++;
            if (dout[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_data_out inst=%0d got=%h exp=%h", i, dout[i], 32'h0);
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(3);
        checks++;
        if (emp[0] !== 1'b1 || vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b%b exp=10", emp[0], vld[0]);
        end
        $display("reset done");
    endtask

    task automatic test_single();
        int k;
        do_reset(0);
        pause = 1'b0;
        push_word(32'hDEADBEEF, 1'b1);
        k = cyc;
        checks++;
        if ({emp[0], fl[0]} !== {1'b0, 4'd1}) begin
            failures++;
            $display("FAIL single_fill got=%b exp=%b", {emp[0], fl[0]}, {1'b0, 4'd1});
        end
        wait_valids(1, 10);
        checks++;
        if (vtimes.size() < 1 || vtimes[0] != k + 1) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=%0d", (vtimes.size() > 0) ? vtimes[0] : -1, k + 1);
        end
        step(4);
        checks++;
        if (vtimes.size() != 1 || emp[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_pulse got=%0d/%b exp=1/1", vtimes.size(), emp[0]);
        end
    endtask

    task automatic test_period4();
        do_reset(2);
        pause = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_word(32'(i), 1'b1);
            checks++;
            if (af[2] !== ((i + 1) >= 6)) begin
                failures++;
                $display("FAIL almost_full fill=%0d got=%b exp=%b", i + 1, af[2], ((i + 1) >= 6));
            end
        end
        checks++;
        if ({ful[2], fl[2]} !== {1'b1, 4'd8}) begin
            failures++;
            $display("FAIL full_after_8 got=%b exp=%b", {ful[2], fl[2]}, {1'b1, 4'd8});
        end
        pause = 1'b0;
        step(1);
        checks++;
        if ({ful[2], fl[2]} !== {1'b0, 4'd7}) begin
            failures++;
            $display("FAIL full_after_pop got=%b exp=%b", {ful[2], fl[2]}, {1'b0, 4'd7});
        end
        wait_valids(8, 60);
        for (int i = 1; i < 8; i++) begin
            if (i < vtimes.size()) begin
                checks++;
                if (vtimes[i] - vtimes[i-1] != 4) begin
                    failures++;
                    $display("FAIL spacing4 idx=%0d got=%0d exp=4", i, vtimes[i] - vtimes[i-1]);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL period4_drain got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_overflow();
        do_reset(0);
        pause = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_word(32'h100 + 32'(i), i < 8);
        end
        checks++;
        if ({ovf[0], fl[0]} !== {1'b1, 4'd8}) begin
            failures++;
            $display("FAIL overflow_set got=%b exp=%b", {ovf[0], fl[0]}, {1'b1, 4'd8});
        end
        pause = 1'b0;
        wait_valids(8, 40);
        step(5);
        checks++;
        if (vtimes.size() != 8 || sb.size() != 0) begin
            failures++;
            $display("FAIL overflow_count got=%0d/%0d exp=8/0", vtimes.size(), sb.size());
        end
        checks++;
        if ({ovf[0], emp[0]} !== 2'b11) begin
            failures++;
            $display("FAIL overflow_sticky got=%b exp=11", {ovf[0], emp[0]});
        end
    endtask

    task automatic test_back_to_back();
        do_reset(0);
        pause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_word(32'h200 + 32'(i), 1'b1);
            checks++;
            if (fl[0] !== 4'd1) begin
                failures++;
                $display("FAIL steady_fill idx=%0d got=%0d exp=1", i, fl[0]);
            end
        end
        wait_valids(20, 30);
        checks++;
        if (vtimes.size() != 20 || vtimes[19] - vtimes[0] != 19) begin
            failures++;
            $display("FAIL back_to_back_span got=%0d exp=19",
                     (vtimes.size() == 20) ? vtimes[19] - vtimes[0] : -1);
        end
        checks++;
        if (sb.size() != 0 || emp[0] !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_drain got=%0d/%b exp=0/1", sb.size(), emp[0]);
        end
    endtask

    task automatic test_pause_gap();
        int p_pop;
        int r;
        do_reset(1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'h300 + 32'(i), 1'b1);
        pause = 1'b0;
        step(1);
        p_pop = cyc;
        step(1);
        pause = 1'b1;
        step(6);
        checks++;
        if (vtimes.size() != 1 || vtimes[0] != p_pop) begin
            failures++;
            $display("FAIL pause_hold got=%0d exp=1", vtimes.size());
        end
        r = cyc;
        pause = 1'b0;
        step(3);
        checks++;
        if (vtimes.size() < 2 || vtimes[1] != r + 1) begin
            failures++;
            $display("FAIL pause_release got=%0d exp=%0d", (vtimes.size() > 1) ? vtimes[1] : -1, r + 1);
        end
        wait_valids(3, 20);
        checks++;
        if (vtimes.size() == 3 && vtimes[2] - vtimes[1] != 3) begin
            failures++;
            $display("FAIL spacing3 got=%0d exp=3", vtimes[2] - vtimes[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        pause = 1'b1;
        for (int i = 0; i < 6; i++) push_word(32'h400 + 32'(i), 1'b1);
        pause = 1'b0;
        step(1);
        checks++;
        if ({vld[2], fl[2]} !== {1'b1, 4'd5}) begin
            failures++;
            $display("FAIL mid_setup got=%b exp=%b", {vld[2], fl[2]}, {1'b1, 4'd5});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({vld[2], emp[2], fl[2]} !== {1'b0, 1'b1, 4'd0} || dout[2] !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got=%b/%h exp=%b/%h", {vld[2], emp[2], fl[2]}, dout[2],
                     {1'b0, 1'b1, 4'd0}, 32'h0);
        end
        sb.delete();
        vtimes.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(20);
        checks++;
        if (vtimes.size() != 0 || emp[2] !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_quiet got=%0d/%b exp=0/1", vtimes.size(), emp[2]);
        end
    endtask

    initial begin
        reset   = 1'b0;
        push    = 1'b0;
        pause   = 1'b1;
        data_in = 32'h0;
        test_reset();
        test_single();
        test_period4();
        test_overflow();
        test_back_to_back();
        test_pause_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
